prog_delay_timer: RTL and testbench

- Parametrised programmable delay/interval timer, the successor to the fixed 0.5 s power-on delay.
- Counts a programmable number of prescaled ticks of the 50 MHz system clock, then flags expiry.
- Supports one-shot and periodic modes, start/stop/restart control, and an optional auto-start after reset.
- Used for power-on settle delays, display refresh strobes and debounce windows in the counter/seven-segment design.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/prog_delay_timer_if.sv | 23 ++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/prog_delay_timer.sv | 112 +++++++++++
 tb/tb_prog_delay_timer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types, mode encodings and tick-conversion helper for the programmable delay timer.
package timer_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Milliseconds to timer ticks for a given clock and prescale divider.
    function automatic logic [31:0] ms_to_ticks(input int unsigned ms,
                                                input int unsigned clk_hz,
                                                input int unsigned div);
        logic [63:0] t;
        t = 64'(ms) * 64'(clk_hz) / 64'(1000);
        if (div > 1) begin
            t = t / 64'(div);
        end
        return t[31:0];
    endfunction

endpackage

// File: rtl/prog_delay_timer_if.sv
// Control/status bundle between a timer client (master) and the timer (slave).
interface prog_delay_timer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic             busy;
    logic             done;
    logic             expire;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, stop, mode, load_val,
        input  busy, done, expire, remaining
    );

    modport slave (
        input  start, stop, mode, load_val,
        output busy, done, expire, remaining
    );
endinterface

// File: rtl/tick_prescaler.sv
// Registered tick enable every DIV cycles; clear restarts the phase so the
// first enable appears DIV cycles after the clearing edge.
module tick_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_en
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_en_q, tick_en_d;
    logic          wrap_c;

    always_comb begin
        cnt_d     = cnt_q;
        wrap_c    = (cnt_q == CW'(DIV - 1));
        tick_en_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else begin
            tick_en_d = wrap_c;
            cnt_d     = wrap_c ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_en_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_en_q <= tick_en_d;
        end
    end

    assign tick_en = tick_en_q;
endmodule

// File: rtl/prog_delay_timer.sv
// Programmable one-shot/periodic delay timer counting prescaled clock ticks,
// with optional auto-start of a default one-shot after reset.
module prog_delay_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned PRESC_DIV     = 1,
    parameter bit          AUTO_START    = 1'b1,
    parameter int unsigned DEFAULT_TICKS = ms_to_ticks(500, CLK_HZ, PRESC_DIV)
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_delay_timer_if.slave    bus
);
    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             expire_q, expire_d;
    logic             mode_q, mode_d;
    logic             auto_q, auto_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] period_q, period_d;

    logic             start_c;
    logic             mode_c;
    logic [CNT_W-1:0] ld_c;
    logic [CNT_W-1:0] n_c;
    logic             presc_clear_c;
    logic             tick_en;

    tick_prescaler #(.DIV(PRESC_DIV)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .clear   (presc_clear_c),
        .tick_en (tick_en)
    );

    // Next-state: stop beats start, start beats a coincident expiry.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        expire_d      = 1'b0;
        mode_d        = mode_q;
        rem_d         = rem_q;
        period_d      = period_q;
        auto_d        = 1'b0;
        presc_clear_c = 1'b0;

        start_c = bus.start | auto_q;
        ld_c    = auto_q ? CNT_W'(DEFAULT_TICKS) : bus.load_val;
        mode_c  = auto_q ? MODE_ONESHOT : bus.mode;
        n_c     = (ld_c == '0) ? CNT_W'(1) : ld_c;

        if (bus.stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
        end else if (start_c) begin
            state_d       = ST_RUN;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            mode_d        = mode_c;
            period_d      = n_c;
            rem_d         = n_c - CNT_W'(1);
            presc_clear_c = 1'b1;
        end else if ((state_q == ST_RUN) && tick_en) begin
            if (rem_q != '0) begin
                rem_d = rem_q - CNT_W'(1);
            end else begin
                expire_d = 1'b1;
                done_d   = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    rem_d = period_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            expire_q <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            auto_q   <= AUTO_START;
            rem_q    <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            expire_q <= expire_d;
            mode_q   <= mode_d;
            auto_q   <= auto_d;
            rem_q    <= rem_d;
            period_q <= period_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.expire    = expire_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_prog_delay_timer.sv
// Scoreboard bench: the driver predicts each post-edge status from an
// event-time model of the timer; a monitor pops and compares every cycle.
module tb_prog_delay_timer;
    localparam int unsigned CNT_W = 8;
    localparam int          DIV   = 3;
    localparam int          DEF   = 5;
    localparam bit          AUTO  = 1'b1;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             expire;
        logic [CNT_W-1:0] rem;
    } obs_t;

    logic clk;
    logic rst;

    prog_delay_timer_if #(.CNT_W(CNT_W)) tif ();

    prog_delay_timer #(
        .CNT_W         (CNT_W),
        .PRESC_DIV     (DIV),
        .AUTO_START    (AUTO),
        .DEFAULT_TICKS (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   mon_n  = 0;

    // Model: a run started at edge t with period N consumes ticks at edges
    // t+1+k*DIV (k>=1); every N-th consumed tick is an expiry.
    bit m_run, m_done, m_mode, m_auto;
    int m_t, m_n;

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy   = tif.busy;
        o.done   = tif.done;
        o.expire = tif.expire;
        o.rem    = tif.remaining;
        return o;
    endfunction

    function automatic int model_rem(int c);
        int d, j;
        d = c - m_t - 1;
        j = (d >= DIV) ? d / DIV : 0;
        return m_n - 1 - (j % m_n);
    endfunction

    task automatic model_edge(bit r, bit s, bit p, bit m, int ld, int c);
        obs_t e;
        bit   s_eff, md;
        int   ld_eff, d;
        e = '0;
        if (r) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_mode = 1'b0;
            m_auto = AUTO;
            exp_q.push_back(e);
            return;
        end
        s_eff  = s | m_auto;
        ld_eff = m_auto ? DEF : ld;
        md     = m_auto ? 1'b0 : m;
        m_auto = 1'b0;
        if (p) begin
            m_run = 1'b0;
        end else if (s_eff) begin
            m_run  = 1'b1;
            m_t    = c;
            m_n    = (ld_eff == 0) ? 1 : ld_eff;
            m_mode = md;
            m_done = 1'b0;
        end else if (m_run) begin
            d = c - m_t - 1;
            if (d >= DIV && (d % DIV) == 0 && ((d / DIV) % m_n) == 0) begin
                e.expire = 1'b1;
                m_done   = 1'b1;
                if (!m_mode) m_run = 1'b0;
            end
        end
        e.busy = m_run;
        e.done = m_done;
        e.rem  = m_run ? CNT_W'(model_rem(c)) : '0;
        exp_q.push_back(e);
    endtask

    // Drive one edge's inputs during the low phase and queue the prediction.
    task automatic step(bit s, bit p, bit m, int ld);
        tif.start    = s;
        tif.stop     = p;
        tif.mode     = m;
        tif.load_val = CNT_W'(ld);
        model_edge(rst, s, p, m, ld, edge_n);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic check_zero(string name);
        obs_t o;
        o = dut_obs();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL %s: got busy=%0b done=%0b expire=%0b remaining=%0d, want all zero",
                     name, o.busy, o.done, o.expire, o.rem);
        end
    endtask

    // Asynchronous reset asserted between edges, held for 'hold' edges.
    task automatic reset_pulse(int hold);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        obs_t e, o;
        forever begin
            @(posedge clk);
            #2;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow at edge %0d", mon_n);
            end else begin
                e = exp_q.pop_front();
                o = dut_obs();
                if (o !== e) begin
                    errors++;
                    $display("FAIL status edge %0d: got busy=%0b done=%0b expire=%0b remaining=%0d, want busy=%0b done=%0b expire=%0b remaining=%0d",
                             mon_n, o.busy, o.done, o.expire, o.rem, e.busy, e.done, e.expire, e.rem);
                end
            end
            mon_n++;
        end
    end

    initial begin : driver
        int r;
        tif.start = 1'b0; tif.stop = 1'b0; tif.mode = 1'b0; tif.load_val = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_zero("reset_state");

        // Power-on auto-start of the default one-shot.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        repeat (22) step(0, 0, 0, 0);

        // Periodic, N=3.
        step(1, 0, 1, 3);
        repeat (40) step(0, 0, 0, 0);

        // Stop mid-run, then a short one-shot.
        step(1, 0, 0, 10);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 2);
        repeat (10) step(0, 0, 0, 0);

        // Restart with a shorter load; start with stop together.
        step(1, 0, 0, 8);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 2);
        repeat (10) step(0, 0, 0, 0);
        step(1, 0, 0, 4);
        repeat (2) step(0, 0, 0, 0);
        step(1, 1, 0, 4);
        repeat (3) step(0, 0, 0, 0);

        // load_val=0 behaves as 1; start landing on an expiry edge.
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        step(1, 0, 0, 2);
        repeat (6) step(0, 0, 0, 0);
        step(1, 0, 0, 3);
        repeat (15) step(0, 0, 0, 0);

        // Reset mid-run, auto-start repeats after release.
        step(1, 0, 1, 4);
        repeat (5) step(0, 0, 0, 0);
        reset_pulse(2);
        repeat (25) step(0, 0, 0, 0);

        // Randomised control traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 17) begin
                reset_pulse(int'($urandom_range(1, 2)));
            end else begin
                step(r < 12 || r == 16, (r >= 12 && r <= 16), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 7)));
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
